// File: rtl/cp0_timer_int_pkg.sv
// cp0_timer_int_pkg
//   Shared types and constants for the CP0 Count/Compare timer and the
//   interrupt-source block that feeds CP0 Cause[15:10].
//   Contents: CP0 register numbers for Count and Compare, bus widths,
//   enable levels, the zero word and a write-qualify helper.
package cp0_timer_int_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CP0_INT_W  = 6;

  typedef logic [REG_W-1:0]      reg_bus_t;       // REG_BUS
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;  // REG_ADDR_BUS
  typedef logic [CP0_INT_W-1:0]  cp0_int_bus_t;   // CP0_INT_BUS (5:0)

  localparam reg_addr_bus_t CP0_COUNT   = 5'd9;
  localparam reg_addr_bus_t CP0_COMPARE = 5'd11;

  localparam logic     WRITE_ENABLE = 1'b1;
  localparam logic     READ_ENABLE  = 1'b1;
  localparam reg_bus_t ZERO_WORD    = 32'h0000_0000;

  // A CP0 write only takes effect when it is enabled and not squashed by a
  // flush in the same cycle.
  function automatic logic wr_hit(input logic we, input logic exc_flush,
                                  input reg_addr_bus_t waddr,
                                  input reg_addr_bus_t target);
    return (we == WRITE_ENABLE) && !exc_flush && (waddr == target);
  endfunction

endpackage

// File: rtl/cp0_timer_int_if.sv
// cp0_timer_int_if
//   MEM-stage CP0 write/read bus shared by CP0 and the timer block.
//   No handshake: a write is accepted in the cycle it is presented, a read
//   returns combinational data in the same cycle.
//   Signals:
//     we, waddr, wdata : CP0 write port
//     re, raddr        : CP0 read port
//     exc_flush        : squashes this cycle's write
//     data_o           : read data (Count/Compare, else zero)
//   Modports: master drives the bus (pipeline side), slave is the timer.
interface cp0_timer_int_if;
  import cp0_timer_int_pkg::*;

  logic          we;
  reg_addr_bus_t waddr;
  reg_bus_t      wdata;
  logic          re;
  reg_addr_bus_t raddr;
  logic          exc_flush;
  reg_bus_t      data_o;

  modport master (
    output we, waddr, wdata, re, raddr, exc_flush,
    input  data_o
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, exc_flush,
    output data_o
  );

endinterface

// File: rtl/cp0_timer_int_sync.sv
// int_sync
//   Single-bit level synchronizer for an asynchronous interrupt line.
//   STAGES flip-flops in series, asynchronously cleared by rst.
//   Ports:
//     clk   : destination clock
//     rst   : asynchronous active-high reset
//     d     : raw asynchronous input
//     q     : synchronized output (last stage)
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_timer_int.sv
// cp0_timer_int
//   Interrupt sources for CP0 Cause[15:10]: owns Count (reg 9) and
//   Compare (reg 11), raises a sticky timer interrupt on a Count/Compare
//   match, and synchronizes the six external interrupt lines.
//   Ports:
//     cpu_clk_50M  : clock
//     cpu_rst      : asynchronous active-high reset
//     ext_int_i    : raw asynchronous interrupt levels
//     cp0_bus      : CP0 write/read bus (slave side)
//     int_o        : to CP0 int_i; bit 5 also carries the timer interrupt
//     timer_int_o  : timer pending flag
module cp0_timer_int
  import cp0_timer_int_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  cp0_int_bus_t          ext_int_i,
  cp0_timer_int_if.slave        cp0_bus,
  output cp0_int_bus_t          int_o,
  output logic                  timer_int_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  reg_bus_t         count;
  reg_bus_t         compare;
  reg_bus_t         count_inc;
  logic             timer_pend;
  logic             tick;
  logic             count_wr;
  logic             compare_wr;
  cp0_int_bus_t     ext_sync;

  // ---------------- external interrupt synchronizers ----------------
  for (genvar k = 0; k < CP0_INT_W; k++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (cpu_clk_50M),
      .rst (cpu_rst),
      .d   (ext_int_i[k]),
      .q   (ext_sync[k])
    );
  end

  // ---------------- Count / Compare / pend ----------------
  // With COUNT_DIV == 1 the divider is stuck at 0 == DIV_LAST, so tick is 1.
  assign tick       = (div_cnt == DIV_LAST);
  assign count_inc  = count + 32'd1;
  assign count_wr   = wr_hit(cp0_bus.we, cp0_bus.exc_flush, cp0_bus.waddr, CP0_COUNT);
  assign compare_wr = wr_hit(cp0_bus.we, cp0_bus.exc_flush, cp0_bus.waddr, CP0_COMPARE);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      div_cnt    <= '0;
      count      <= ZERO_WORD;
      compare    <= ZERO_WORD;
      timer_pend <= 1'b0;
    end else begin
      // A Count write restarts the divider and replaces this cycle's increment.
      if (count_wr) begin
        count   <= cp0_bus.wdata;
        div_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          count <= count_inc;
        end
      end

      if (compare_wr) begin
        compare <= cp0_bus.wdata;
      end

      // Compare write wins over a same-edge match; the match itself uses the
      // old Compare, so the new value only participates from the next tick.
      if (compare_wr) begin
        timer_pend <= 1'b0;
      end else if (tick && !count_wr && (count_inc == compare)) begin
        timer_pend <= 1'b1;
      end
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    cp0_bus.data_o = ZERO_WORD;
    if (cp0_bus.re == READ_ENABLE) begin
      if (cp0_bus.raddr == CP0_COUNT) begin
        cp0_bus.data_o = count;
      end else if (cp0_bus.raddr == CP0_COMPARE) begin
        cp0_bus.data_o = compare;
      end
    end
  end

  assign int_o       = {ext_sync[5] | timer_pend, ext_sync[4:0]};
  assign timer_int_o = timer_pend;

endmodule

// File: tb/tb_cp0_timer_int.sv
// tb_cp0_timer_int
//   Directed bench for cp0_timer_int with default parameters
//   (SYNC_STAGES=2, COUNT_DIV=2). Expected values are pushed to exp_q as
//   each step is driven and popped when the DUT output is sampled 1 ns
//   after the clock edge.
module tb_cp0_timer_int;
  import cp0_timer_int_pkg::*;

  logic         cpu_clk_50M;
  logic         cpu_rst;
  cp0_int_bus_t ext_int_i;
  cp0_int_bus_t int_o;
  logic         timer_int_o;

  cp0_timer_int_if bus_if ();

  cp0_timer_int #(.SYNC_STAGES(2), .COUNT_DIV(2)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .ext_int_i   (ext_int_i),
    .cp0_bus     (bus_if),
    .int_o       (int_o),
    .timer_int_o (timer_int_o)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    cpu_clk_50M = 1'b0;
    forever #10 cpu_clk_50M = ~cpu_clk_50M;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: got %h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic rd(input reg_addr_bus_t a, input string tag);
    bus_if.re    = 1'b1;
    bus_if.raddr = a;
    #1;
    chk(tag, bus_if.data_o);
  endtask

  // Presents one write for exactly one clock edge.
  task automatic wr_cycle(input reg_addr_bus_t a, input logic [31:0] d, input logic flush);
    bus_if.we        = 1'b1;
    bus_if.waddr     = a;
    bus_if.wdata     = d;
    bus_if.exc_flush = flush;
    step(1);
    bus_if.we        = 1'b0;
    bus_if.exc_flush = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cpu_rst          = 1'b1;
    ext_int_i        = '0;
    bus_if.we        = 1'b0;
    bus_if.waddr     = '0;
    bus_if.wdata     = '0;
    bus_if.re        = 1'b0;
    bus_if.raddr     = '0;
    bus_if.exc_flush = 1'b0;

    // In reset
    #5;
    push(32'h0); rd(CP0_COUNT, "rst_count");
    push(32'h0); chk("rst_int_o", {26'h0, int_o});
    push(32'h0); chk("rst_timer", {31'h0, timer_int_o});
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;

    // Idle counting: edge 1, 2, 10
    push(32'd0); step(1); rd(CP0_COUNT, "cnt_e1");
    push(32'd1); step(1); rd(CP0_COUNT, "cnt_e2");
    push(32'd5); step(8); rd(CP0_COUNT, "cnt_e10");
    push(32'd0); rd(CP0_COMPARE, "cmp_idle");
    push(32'd0); chk("int_idle", {26'h0, int_o});

    // Compare = 10 -> match when Count becomes 10 (edge 20)
    wr_cycle(CP0_COMPARE, 32'd10, 1'b0);                      // edge 11
    push(32'd9); push(32'd0);
    step(8); rd(CP0_COUNT, "cnt_e19"); chk("timer_e19", {31'h0, timer_int_o});
    push(32'd10); push(32'd1); push(32'h20);
    step(1); rd(CP0_COUNT, "cnt_e20"); chk("timer_e20", {31'h0, timer_int_o});
    chk("int_e20", {26'h0, int_o});
    push(32'd11); push(32'd1);
    step(2); rd(CP0_COUNT, "cnt_e22"); chk("timer_e22", {31'h0, timer_int_o});
    push(32'd12); push(32'd1);
    step(2); rd(CP0_COUNT, "cnt_e24"); chk("timer_e24", {31'h0, timer_int_o});
    push(32'd0); push(32'd0);
    wr_cycle(CP0_COMPARE, 32'd10, 1'b0);                      // edge 25
    chk("timer_clr", {31'h0, timer_int_o}); chk("int_clr", {26'h0, int_o});

    // Wrap: Count write replaces the tick due on edge 26
    push(32'hFFFF_FFFF);
    wr_cycle(CP0_COUNT, 32'hFFFF_FFFF, 1'b0);                 // edge 26
    rd(CP0_COUNT, "cnt_wr_ff");
    push(32'hFFFF_FFFF); push(32'd0);
    wr_cycle(CP0_COMPARE, 32'd0, 1'b0);                       // edge 27
    rd(CP0_COUNT, "cnt_e27"); chk("timer_e27", {31'h0, timer_int_o});
    push(32'd0); push(32'd1); push(32'h20);
    step(1); rd(CP0_COUNT, "cnt_wrap");                       // edge 28
    chk("timer_wrap", {31'h0, timer_int_o}); chk("int_wrap", {26'h0, int_o});

    // Flushed Count write is ignored; pend stays sticky
    wr_cycle(CP0_COUNT, 32'h100, 1'b1);                       // edge 29
    push(32'd1); push(32'd1);
    step(1); rd(CP0_COUNT, "cnt_flush");                      // edge 30
    chk("timer_sticky", {31'h0, timer_int_o});

    // Compare write on the same edge as a would-be match
    push(32'd0);
    wr_cycle(CP0_COMPARE, 32'd3, 1'b0);                       // edge 31
    chk("timer_cmp3", {31'h0, timer_int_o});
    push(32'd2); step(2); rd(CP0_COUNT, "cnt_e33");
    bus_if.we = 1'b1; bus_if.waddr = CP0_COMPARE; bus_if.wdata = 32'h20;
    push(32'd3); rd(CP0_COMPARE, "cmp_old_read");
    push(32'd3); push(32'd0); push(32'h20);
    step(1); bus_if.we = 1'b0;                                // edge 34
    rd(CP0_COUNT, "cnt_e34"); chk("timer_cmpwin", {31'h0, timer_int_o});
    rd(CP0_COMPARE, "cmp_e34");

    // Count write on the edge that would match
    wr_cycle(CP0_COMPARE, 32'd5, 1'b0);                       // edge 35
    push(32'd4); step(2); rd(CP0_COUNT, "cnt_e37");
    push(32'd7); push(32'd0);
    wr_cycle(CP0_COUNT, 32'd7, 1'b0);                         // edge 38
    rd(CP0_COUNT, "cnt_wr7"); chk("timer_cntwin", {31'h0, timer_int_o});
    push(32'd7); step(1); rd(CP0_COUNT, "cnt_e39");
    push(32'd8); step(1); rd(CP0_COUNT, "cnt_e40");

    // ext_int_i[2] high for 5 cycles
    ext_int_i[2] = 1'b1;
    push(32'd0); step(1); chk("ext2_e41", {26'h0, int_o});
    for (int i = 0; i < 5; i++) begin
      push(32'h04); step(1); chk("ext2_hi", {26'h0, int_o});
      if (i == 3) ext_int_i[2] = 1'b0;
    end
    push(32'd0); step(1); chk("ext2_lo", {26'h0, int_o});

    // ext_int_i[5] with pend clear
    ext_int_i[5] = 1'b1;
    push(32'h20); push(32'd0);
    step(2); chk("ext5_int", {26'h0, int_o}); chk("ext5_timer", {31'h0, timer_int_o});

    // Build pend=1 at Count=0x1234, then async reset mid-cycle
    wr_cycle(CP0_COUNT, 32'h1233, 1'b0);                      // edge 50
    wr_cycle(CP0_COMPARE, 32'h1234, 1'b0);                    // edge 51
    push(32'h1234); push(32'd1); push(32'h20);
    step(1); rd(CP0_COUNT, "cnt_1234");
    chk("timer_1234", {31'h0, timer_int_o}); chk("int_1234", {26'h0, int_o});
    #3;
    cpu_rst = 1'b1;
    #1;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    chk("arst_timer", {31'h0, timer_int_o}); chk("arst_int", {26'h0, int_o});
    rd(CP0_COUNT, "arst_count"); rd(CP0_COMPARE, "arst_cmp");
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    push(32'd0); push(32'd0);
    step(1); rd(CP0_COUNT, "post_cnt_e1"); chk("post_int_e1", {26'h0, int_o});
    push(32'd1); push(32'h20);
    step(1); rd(CP0_COUNT, "post_cnt_e2"); chk("post_int_e2", {26'h0, int_o});
    bus_if.re = 1'b0;
    push(32'd0); #1; chk("re_low", bus_if.data_o);

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
